// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: response owner tags,
// arbiter states and the owner FIFO count-width helper.
package mem_arb_pkg;

  typedef enum logic {
    OWN_INSTR = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    HOLD_I = 2'd1,
    HOLD_D = 2'd2
  } arb_state_e;

  // Counter must represent 0..max_out inclusive.
  function automatic int fifo_cnt_w(input int max_out);
    return $clog2(max_out) + 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_owner_fifo.sv
// In-order FIFO of response owners; one entry per granted, not yet answered
// memory transaction.
module owner_fifo
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push_in,
  input  owner_e push_owner_in,
  input  logic   pop_in,
  output owner_e head_out,
  output logic   full_out,
  output logic   empty_out
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = fifo_cnt_w(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  owner_e            mem_q [DEPTH];
  owner_e            mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              do_push_s, do_pop_s;

  // Explicit wrap keeps non-power-of-two depths correct as well.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == LAST_PTR) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  assign full_out  = (cnt_q == FULL_CNT);
  assign empty_out = (cnt_q == {CNT_W{1'b0}});
  assign head_out  = mem_q[rd_ptr_q];
  assign do_push_s = push_in && !full_out;
  assign do_pop_s  = pop_in && !empty_out;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push_s) begin
      mem_d[wr_ptr_q] = push_owner_in;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= OWN_INSTR;
      end
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-to-one instruction/data arbiter onto a single req/gnt/rvalid memory port,
// data-favoured with an instruction starvation guard and in-order response routing.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_OUT      = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                req,
  input  logic                reset,
  input  logic                instr_req_in,
  input  logic [ADDR_W-1:0]   instr_addr_in,
  output logic                instr_gnt_out,
  output logic                instr_rvalid_out,
  output logic [DATA_W-1:0]   instr_rdata_out,
  input  logic                data_req_in,
  input  logic [ADDR_W-1:0]   data_addr_in,
  input  logic [DATA_W-1:0]   data_wdata_in,
  input  logic [DATA_W/8-1:0] data_be_in,
  input  logic                data_we_in,
  output logic                data_gnt_out,
  output logic                data_rvalid_out,
  output logic [DATA_W-1:0]   data_rdata_out,
  output logic                mem_req_out,
  output logic [ADDR_W-1:0]   mem_addr_out,
  output logic [DATA_W-1:0]   mem_wdata_out,
  output logic [DATA_W/8-1:0] mem_be_out,
  output logic                mem_we_out,
  input  logic                mem_gnt_in,
  input  logic                mem_rvalid_in,
  input  logic [DATA_W-1:0]   mem_rdata_in,
  output logic                err_out
);

  localparam int BE_W = DATA_W / 8;
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);

  arb_state_e       state_q, state_d;
  logic [SC_W-1:0]  starve_q, starve_d;
  logic             err_q, err_d;
  owner_e           owner_s;
  owner_e           fifo_head_s;
  logic             win_req_s, hs_s, pop_s;
  logic             fifo_full_s, fifo_empty_s;

  // Owner selection: free arbitration in ARB, frozen while an address phase waits.
  always_comb begin
    owner_s = OWN_INSTR;
    case (state_q)
      ARB: begin
        if (data_req_in && !((starve_q == STARVE_MAX) && instr_req_in)) begin
          owner_s = OWN_DATA;
        end else begin
          owner_s = OWN_INSTR;
        end
      end
      HOLD_I:  owner_s = OWN_INSTR;
      HOLD_D:  owner_s = OWN_DATA;
      default: owner_s = OWN_INSTR;
    endcase
  end

  assign win_req_s     = (owner_s == OWN_DATA) ? data_req_in : instr_req_in;
  assign mem_req_out   = win_req_s && !fifo_full_s && !reset;
  assign hs_s          = mem_req_out && mem_gnt_in;
  assign instr_gnt_out = hs_s && (owner_s == OWN_INSTR);
  assign data_gnt_out  = hs_s && (owner_s == OWN_DATA);

  // Downstream address-phase mux; instruction fetches are full-word reads.
  always_comb begin
    mem_addr_out  = instr_addr_in;
    mem_wdata_out = {DATA_W{1'b0}};
    mem_be_out    = {BE_W{1'b1}};
    mem_we_out    = 1'b0;
    if (owner_s == OWN_DATA) begin
      mem_addr_out  = data_addr_in;
      mem_wdata_out = data_wdata_in;
      mem_be_out    = data_be_in;
      mem_we_out    = data_we_in;
    end else begin
      mem_addr_out  = instr_addr_in;
      mem_wdata_out = {DATA_W{1'b0}};
      mem_be_out    = {BE_W{1'b1}};
      mem_we_out    = 1'b0;
    end
  end

  // A response with nothing outstanding is dropped rather than misrouted.
  assign pop_s            = mem_rvalid_in && !fifo_empty_s && !reset;
  assign instr_rvalid_out = pop_s && (fifo_head_s == OWN_INSTR);
  assign data_rvalid_out  = pop_s && (fifo_head_s == OWN_DATA);
  assign instr_rdata_out  = mem_rdata_in;
  assign data_rdata_out   = mem_rdata_in;
  assign err_out          = err_q;

  // Next state for lock FSM, starvation counter and sticky error.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    err_d    = err_q | (mem_rvalid_in && fifo_empty_s);
    case (state_q)
      ARB: begin
        if (win_req_s && !hs_s) begin
          state_d = (owner_s == OWN_DATA) ? HOLD_D : HOLD_I;
        end else begin
          state_d = ARB;
        end
      end
      HOLD_I, HOLD_D: begin
        if (hs_s) begin
          state_d = ARB;
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = ARB;
    endcase
    if (hs_s && (owner_s == OWN_DATA) && instr_req_in && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + SC_W'(1);
    end else if (hs_s && (owner_s == OWN_INSTR)) begin
      starve_d = {SC_W{1'b0}};
    end else begin
      starve_d = starve_q;
    end
  end

  // Arbiter state registers.
  always_ff @(posedge req or posedge reset) begin
    if (reset) begin
      state_q  <= ARB;
      starve_q <= {SC_W{1'b0}};
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      err_q    <= err_d;
    end
  end

  owner_fifo #(
    .DEPTH(MAX_OUT)
  ) u_owner_fifo (
    .clk          (req),
    .reset        (reset),
    .push_in      (hs_s),
    .push_owner_in(owner_s),
    .pop_in       (pop_s),
    .head_out     (fifo_head_s),
    .full_out     (fifo_full_s),
    .empty_out    (fifo_empty_s)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed vector bench for mem_arbiter: cycle table plus starvation and reset sequences.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_req, data_req, data_we, mem_gnt, mem_rvalid;
  logic [31:0] instr_addr, data_addr, data_wdata, mem_rdata;
  logic [3:0]  data_be;
  logic        instr_gnt, instr_rvalid, data_gnt, data_rvalid;
  logic [31:0] instr_rdata, data_rdata;
  logic        mem_req, mem_we, err;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_OUT(2), .STARVE_LIMIT(4)
  ) dut (
    .req(clk), .reset(rst),
    .instr_req_in(instr_req), .instr_addr_in(instr_addr),
    .instr_gnt_out(instr_gnt), .instr_rvalid_out(instr_rvalid), .instr_rdata_out(instr_rdata),
    .data_req_in(data_req), .data_addr_in(data_addr), .data_wdata_in(data_wdata),
    .data_be_in(data_be), .data_we_in(data_we),
    .data_gnt_out(data_gnt), .data_rvalid_out(data_rvalid), .data_rdata_out(data_rdata),
    .mem_req_out(mem_req), .mem_addr_out(mem_addr), .mem_wdata_out(mem_wdata),
    .mem_be_out(mem_be), .mem_we_out(mem_we),
    .mem_gnt_in(mem_gnt), .mem_rvalid_in(mem_rvalid), .mem_rdata_in(mem_rdata),
    .err_out(err)
  );

  typedef struct {
    logic ireq; logic [31:0] ia;
    logic dreq; logic [31:0] da; logic we; logic [3:0] be; logic [31:0] wd;
    logic gnt; logic rv; logic [31:0] rd;
    logic e_mreq; logic [31:0] e_addr; logic e_we; logic [3:0] e_be; logic [31:0] e_wd;
    logic e_igt; logic e_dgt; logic e_irv; logic e_drv; logic e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int ireq, int ia, int dreq, int da, int we, int be, int wd,
                              int gnt, int rv, int rd,
                              int mreq, int maddr, int mwe, int mbe, int mwd,
                              int igt, int dgt, int irv, int drv, int e);
    vec_t v;
    v.ireq = ireq[0]; v.ia = 32'(ia);
    v.dreq = dreq[0]; v.da = 32'(da); v.we = we[0]; v.be = be[3:0]; v.wd = 32'(wd);
    v.gnt = gnt[0]; v.rv = rv[0]; v.rd = 32'(rd);
    v.e_mreq = mreq[0]; v.e_addr = 32'(maddr); v.e_we = mwe[0]; v.e_be = mbe[3:0];
    v.e_wd = 32'(mwd);
    v.e_igt = igt[0]; v.e_dgt = dgt[0]; v.e_irv = irv[0]; v.e_drv = drv[0]; v.e_err = e[0];
    return v;
  endfunction

  task automatic drive(input vec_t v);
    instr_req = v.ireq; instr_addr = v.ia;
    data_req = v.dreq; data_addr = v.da; data_we = v.we; data_be = v.be; data_wdata = v.wd;
    mem_gnt = v.gnt; mem_rvalid = v.rv; mem_rdata = v.rd;
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %b expected %b", nm, act, exp);
    else n_pass++;
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t idle;
    logic exp_i, prev_i;
    idle = mk(0,0, 0,0,0,0,0, 0, 0,0, 0,0,0,0,0, 0,0,0,0,0);

    // Instruction-only read, zero-wait memory.
    vecs.push_back(mk(1,'h100, 0,0,0,0,0, 1, 0,0,          1,'h100,0,'hF,0,       1,0,0,0,0));
    vecs.push_back(mk(0,0, 0,0,0,0,0, 0, 1,'hDEADBEEF,     0,0,0,0,0,             0,0,1,0,0));
    // Simultaneous requests: data first, instruction next, responses in order.
    vecs.push_back(mk(1,'h200, 1,'h300,1,'h3,'h12345678, 1, 0,0, 1,'h300,1,'h3,'h12345678, 0,1,0,0,0));
    vecs.push_back(mk(1,'h200, 0,0,0,0,0, 1, 1,'hAAAA,     1,'h200,0,'hF,0,       1,0,0,1,0));
    vecs.push_back(mk(0,0, 0,0,0,0,0, 0, 1,'h5555,         0,0,0,0,0,             0,0,1,0,0));
    // Instruction address phase held while a data request arrives.
    vecs.push_back(mk(1,'h400, 0,0,0,0,0, 0, 0,0,          1,'h400,0,'hF,0,       0,0,0,0,0));
    vecs.push_back(mk(1,'h400, 1,'h500,0,'hF,0, 0, 0,0,    1,'h400,0,'hF,0,       0,0,0,0,0));
    vecs.push_back(mk(1,'h400, 1,'h500,0,'hF,0, 0, 0,0,    1,'h400,0,'hF,0,       0,0,0,0,0));
    vecs.push_back(mk(1,'h400, 1,'h500,0,'hF,0, 1, 0,0,    1,'h400,0,'hF,0,       1,0,0,0,0));
    vecs.push_back(mk(0,0, 1,'h500,0,'hF,0, 1, 1,'h11,     1,'h500,0,'hF,0,       0,1,1,0,0));
    vecs.push_back(mk(0,0, 0,0,0,0,0, 0, 1,'h22,           0,0,0,0,0,             0,0,0,1,0));
    // Two outstanding fills the owner FIFO; a pop does not bypass.
    vecs.push_back(mk(0,0, 1,'h600,1,'hF,'hA, 1, 0,0,      1,'h600,1,'hF,'hA,     0,1,0,0,0));
    vecs.push_back(mk(0,0, 1,'h604,1,'hF,'hB, 1, 0,0,      1,'h604,1,'hF,'hB,     0,1,0,0,0));
    vecs.push_back(mk(0,0, 1,'h608,1,'hF,'hC, 1, 0,0,      0,0,0,0,0,             0,0,0,0,0));
    vecs.push_back(mk(0,0, 1,'h608,1,'hF,'hC, 1, 1,'h66,   0,0,0,0,0,             0,0,0,1,0));
    vecs.push_back(mk(0,0, 1,'h608,1,'hF,'hC, 1, 0,0,      1,'h608,1,'hF,'hC,     0,1,0,0,0));
    vecs.push_back(mk(0,0, 0,0,0,0,0, 0, 1,'h77,           0,0,0,0,0,             0,0,0,1,0));
    vecs.push_back(mk(0,0, 0,0,0,0,0, 0, 1,'h88,           0,0,0,0,0,             0,0,0,1,0));
    // Stray response with nothing outstanding.
    vecs.push_back(mk(0,0, 0,0,0,0,0, 0, 1,'h33,           0,0,0,0,0,             0,0,0,0,0));
    vecs.push_back(mk(0,0, 0,0,0,0,0, 0, 0,0,              0,0,0,0,0,             0,0,0,0,1));
    vecs.push_back(mk(0,0, 0,0,0,0,0, 0, 0,0,              0,0,0,0,0,             0,0,0,0,1));

    // Reset forces the request/response strobes low even with live inputs.
    rst = 1'b1;
    drive(mk(1,'h10, 1,'h20,0,'hF,0, 1, 1,'h99, 0,0,0,0,0, 0,0,0,0,0));
    @(negedge clk);
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_igt", instr_gnt, 1'b0);
    chk1("rst_dgt", data_gnt, 1'b0);
    chk1("rst_irv", instr_rvalid, 1'b0);
    chk1("rst_drv", data_rvalid, 1'b0);
    chk1("rst_err", err, 1'b0);
    next_cycle();
    rst = 1'b0;
    drive(idle);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      @(negedge clk);
      chk1($sformatf("v%0d_mem_req", i), mem_req, vecs[i].e_mreq);
      if (vecs[i].e_mreq) begin
        chk32($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].e_addr);
        chk1($sformatf("v%0d_mem_we", i), mem_we, vecs[i].e_we);
        chk32($sformatf("v%0d_mem_be", i), {28'd0, mem_be}, {28'd0, vecs[i].e_be});
        chk32($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].e_wd);
      end
      chk1($sformatf("v%0d_instr_gnt", i), instr_gnt, vecs[i].e_igt);
      chk1($sformatf("v%0d_data_gnt", i), data_gnt, vecs[i].e_dgt);
      chk1($sformatf("v%0d_instr_rvalid", i), instr_rvalid, vecs[i].e_irv);
      chk1($sformatf("v%0d_data_rvalid", i), data_rvalid, vecs[i].e_drv);
      chk1($sformatf("v%0d_err", i), err, vecs[i].e_err);
      if (vecs[i].e_irv) chk32($sformatf("v%0d_instr_rdata", i), instr_rdata, vecs[i].rd);
      if (vecs[i].e_drv) chk32($sformatf("v%0d_data_rdata", i), data_rdata, vecs[i].rd);
      next_cycle();
    end

    // Continuous contention: four data grants, then one instruction grant.
    prev_i = 1'b0;
    for (int k = 0; k < 10; k++) begin
      exp_i = ((k % 5) == 4);
      drive(mk(1,'h700, 1,'h800,0,'hF,0, 1, (k > 0) ? 1 : 0, k, 0,0,0,0,0, 0,0,0,0,0));
      @(negedge clk);
      chk1($sformatf("starve%0d_igt", k), instr_gnt, exp_i);
      chk1($sformatf("starve%0d_dgt", k), data_gnt, !exp_i);
      chk32($sformatf("starve%0d_addr", k), mem_addr, exp_i ? 32'h700 : 32'h800);
      chk1($sformatf("starve%0d_irv", k), instr_rvalid, (k > 0) && prev_i);
      chk1($sformatf("starve%0d_drv", k), data_rvalid, (k > 0) && !prev_i);
      prev_i = exp_i;
      next_cycle();
    end
    drive(mk(0,0, 0,0,0,0,0, 0, 1,'h1234, 0,0,0,0,0, 0,0,0,0,0));
    @(negedge clk);
    chk1("starve_drain_irv", instr_rvalid, prev_i);
    chk1("starve_drain_drv", data_rvalid, !prev_i);
    next_cycle();

    // Saturate the starvation counter, leave one response outstanding, then reset.
    for (int k = 0; k < 4; k++) begin
      drive(mk(1,'h900, 1,'hA00,0,'hF,0, 1, (k > 0) ? 1 : 0, 0, 0,0,0,0,0, 0,0,0,0,0));
      @(negedge clk);
      chk1($sformatf("pre_rst%0d_dgt", k), data_gnt, 1'b1);
      next_cycle();
    end
    rst = 1'b1;
    drive(mk(1,'h900, 1,'hA00,0,'hF,0, 1, 1,0, 0,0,0,0,0, 0,0,0,0,0));
    #1;
    chk1("midrst_err_cleared", err, 1'b0);
    @(negedge clk);
    chk1("midrst_mem_req", mem_req, 1'b0);
    chk1("midrst_dgt", data_gnt, 1'b0);
    chk1("midrst_igt", instr_gnt, 1'b0);
    chk1("midrst_drv", data_rvalid, 1'b0);
    next_cycle();
    rst = 1'b0;
    drive(mk(0,0, 0,0,0,0,0, 0, 1,'h55, 0,0,0,0,0, 0,0,0,0,0));
    @(negedge clk);
    chk1("postrst_stray_irv", instr_rvalid, 1'b0);
    chk1("postrst_stray_drv", data_rvalid, 1'b0);
    next_cycle();
    drive(mk(1,'hB00, 1,'hC00,0,'hF,0, 1, 0,0, 0,0,0,0,0, 0,0,0,0,0));
    @(negedge clk);
    chk1("postrst_err_set", err, 1'b1);
    chk1("postrst_starve_clear_dgt", data_gnt, 1'b1);
    chk1("postrst_starve_clear_igt", instr_gnt, 1'b0);
    next_cycle();
    drive(idle);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
